way_grant_arbiter: RTL and testbench
====================================

# way_grant_arbiter

Parametrised, registered successor to the cache's 8-to-3 priority encoder. It selects one of N requesters, either by fixed MSB-first priority or by round-robin, and presents the winner as a held one-hot/encoded grant with a valid/ready handshake. It sits between the way-hit/victim request vectors and the data-array phase logic, which consumes one grant per accepted handshake.

## Interface
- N, default 8: requester count; legal values N >= 2.
- RR_MODE, default 1: 0 = fixed priority (highest index wins), 1 = round-robin.
- W, derived localparam clog2(N): width of the encoded grant.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  permits new arbitration; does not cancel an outstanding grant.
- req  input  N  request vector, bit i = requester i.
- grant_ready  input  1  consumer accepts the current grant.
- grant_valid  output  1  grant_onehot/grant_idx hold a live grant.
- grant_onehot  output  N  one-hot winner; all zero when grant_valid = 0.
- grant_idx  output  W  encoded winner; zero when grant_valid = 0.

## Operation
- Internal round-robin pointer ptr, W bits, range 0..N-1. Search starts at ptr and proceeds downward: ptr, ptr-1, …, 0, N-1, …, ptr+1. The first set req bit in that order wins.
- In fixed mode ptr is constant at N-1, which gives pure MSB-first priority.
- States:
  - IDLE: grant_valid = 0.
    - If enable = 1 and req != 0, register the winner and go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT: grant_valid = 1. grant_onehot and grant_idx stay frozen while grant_ready = 0, even if req changes or drops, or enable falls.
    - On grant_valid & grant_ready, the handshake completes.
    - If RR_MODE = 1, ptr is updated to (g == 0) ? N-1 : g-1, where g is the accepted index.
    - In the same cycle, if enable = 1 and req != 0, a new winner is arbitrated using the updated ptr, and the block stays in GRANT. Otherwise it returns to IDLE.
- Outputs are driven only from registers; no combinational path from req to any output.
- Index arithmetic wraps modulo N, not 2^W, so non-power-of-two N never yields grant_idx >= N.
- At all times grant_onehot == (1 << grant_idx) when grant_valid = 1, and exactly one bit is set.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release):
  - grant_valid = 0, grant_onehot = 0, grant_idx = 0.
  - State = IDLE, ptr = N-1.
- Reset asserted mid-grant clears all state immediately; the outstanding grant is dropped and does not count as accepted.
- Latency: req/enable sampled at edge k → grant_valid high after edge k. One cycle in total.
- Throughput: one grant per cycle while grant_ready = 1 and requests persist (back-to-back, no idle bubble).
- grant_ready while grant_valid = 0 is ignored.
- A requester whose bit is still set after being granted is eligible again. In round-robin mode it is served only after every other active requester.

## Test plan
- Reset: assert rst_n = 0 mid-simulation with grant_valid = 1 → grant_valid, grant_onehot and grant_idx read 0 before the next clk edge. After release with req = 0 → outputs stay 0.
- Fixed priority: RR_MODE = 0, N = 8, enable = 1, req = 8'b1010_0110, grant_ready = 0 for 3 cycles.
  - grant_idx = 7 and grant_onehot = 8'h80 one cycle after req, stable for all 3 cycles.
  - Raise grant_ready with req unchanged → grant_idx = 7 again.
- Round-robin sweep: RR_MODE = 1, N = 8, req = 8'hFF, grant_ready = 1 constant → grant_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles, grant_valid never drops.
- Round-robin fairness and wrap: req = 8'h81, grant_ready = 1 → grant_idx alternates 7,0,7,0. With N = 6 and req = 6'h3F → 5,4,3,2,1,0,5; grant_idx never reaches 6 or 7.
- Hold and enable: grant issued for idx 3, then req → 0 and enable → 0 while grant_ready = 0.
  - Grant stays at idx 3.
  - On grant_ready = 1 → grant_valid = 0 on the following cycle.
  - No new grant until enable = 1 and req != 0.
- Simultaneous events: in the handshake cycle, req switches to only bit 5 → next cycle grant_idx = 5 with no bubble cycle.

Source files
------------

// File: rtl/way_grant_if.sv
// Grant handshake bundle between request/consumer logic and way_grant_arbiter.
// master drives requests and acceptance; slave (the arbiter) drives the grant.
interface way_grant_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         enable;
  logic [N-1:0] req;
  logic         grant_ready;
  logic         grant_valid;
  logic [N-1:0] grant_onehot;
  logic [W-1:0] grant_idx;

  modport master (
    output enable,
    output req,
    output grant_ready,
    input  grant_valid,
    input  grant_onehot,
    input  grant_idx
  );

  modport slave (
    input  enable,
    input  req,
    input  grant_ready,
    output grant_valid,
    output grant_onehot,
    output grant_idx
  );
endinterface

// File: rtl/way_grant_arbiter.sv
// Registered N-way arbiter: fixed MSB-first or round-robin selection, presented
// as a held one-hot/encoded grant on a valid/ready handshake.
//
// state | meaning
// IDLE  | no live grant; arbitrate when enabled and a request is pending
// GRANT | grant frozen until the consumer accepts it
module way_grant_arbiter #(
  parameter int N       = 8,
  parameter bit RR_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  way_grant_if.slave gif
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state;
  logic [W-1:0] ptr;
  logic         grant_valid_q;
  logic [W-1:0] grant_idx_q;
  logic [N-1:0] grant_onehot_q;

  logic         accept;
  logic [W-1:0] search_ptr;
  logic         win_found;
  logic [W-1:0] win_idx;

  function automatic logic [W-1:0] prev_idx(input logic [W-1:0] g);
    return (g == '0) ? LAST_IDX : g - 1'b1;
  endfunction

  assign accept = grant_valid_q & gif.grant_ready;

  // The pointer step for an accepted grant is visible to the same-cycle
  // re-arbitration, which is what keeps back-to-back grants fair.
  assign search_ptr = (RR_MODE && accept) ? prev_idx(grant_idx_q) : ptr;

  always_comb begin
    int           j;
    logic [W-1:0] cand;
    j         = 0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(search_ptr) - k;
      if (j < 0) j = j + N;
      cand = W'(j);
      if (!win_found && gif.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= LAST_IDX;
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gif.enable && win_found) begin
            state          <= GRANT;
            grant_valid_q  <= 1'b1;
            grant_idx_q    <= win_idx;
            grant_onehot_q <= N'(1) << win_idx;
          end
        end
        GRANT: begin
          if (gif.grant_ready) begin
            if (RR_MODE) ptr <= search_ptr;
            if (gif.enable && win_found) begin
              grant_valid_q  <= 1'b1;
              grant_idx_q    <= win_idx;
              grant_onehot_q <= N'(1) << win_idx;
            end else begin
              state          <= IDLE;
              grant_valid_q  <= 1'b0;
              grant_idx_q    <= '0;
              grant_onehot_q <= '0;
            end
          end
        end
        default: begin
          state          <= IDLE;
          grant_valid_q  <= 1'b0;
          grant_idx_q    <= '0;
          grant_onehot_q <= '0;
        end
      endcase
    end
  end

  assign gif.grant_valid  = grant_valid_q;
  assign gif.grant_idx    = grant_idx_q;
  assign gif.grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_way_grant_arbiter.sv
// Bench for way_grant_arbiter: three instances (fixed N=8, round-robin N=8,
// round-robin N=6) checked by directed scenarios and a random run against a reference model.
module tb_way_grant_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  way_grant_if #(.N(8)) f8 ();
  way_grant_if #(.N(8)) r8 ();
  way_grant_if #(.N(6)) r6 ();

  way_grant_arbiter #(.N(8), .RR_MODE(1'b0)) u_fix8 (.clk(clk), .rst_n(rst_n), .gif(f8));
  way_grant_arbiter #(.N(8), .RR_MODE(1'b1)) u_rr8  (.clk(clk), .rst_n(rst_n), .gif(r8));
  way_grant_arbiter #(.N(6), .RR_MODE(1'b1)) u_rr6  (.clk(clk), .rst_n(rst_n), .gif(r6));

  // Reference model: instance 0 = fixed/8, 1 = rr/8, 2 = rr/6
  int n_of[3]  = '{8, 8, 6};
  int rr_of[3] = '{0, 1, 1};
  int m_v[3];
  int m_i[3];
  int m_p[3];

  function automatic int pick(input logic [7:0] r, input int start, input int n);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (start - k + n) % n;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic       in_en[3];
    logic [7:0] in_rq[3];
    logic       in_rd[3];
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_v[k] = 0; m_i[k] = 0; m_p[k] = n_of[k] - 1;
      end
    end else begin
      in_en[0] = f8.enable; in_rq[0] = f8.req;      in_rd[0] = f8.grant_ready;
      in_en[1] = r8.enable; in_rq[1] = r8.req;      in_rd[1] = r8.grant_ready;
      in_en[2] = r6.enable; in_rq[2] = 8'(r6.req);  in_rd[2] = r6.grant_ready;
      for (int k = 0; k < 3; k++) begin
        if (m_v[k] == 0 || in_rd[k]) begin
          if (m_v[k] != 0 && rr_of[k] != 0)
            m_p[k] = (m_i[k] == 0) ? n_of[k] - 1 : m_i[k] - 1;
          if (in_en[k] && in_rq[k] != 8'h00) begin
            m_v[k] = 1;
            m_i[k] = pick(in_rq[k], m_p[k], n_of[k]);
          end else begin
            m_v[k] = 0;
            m_i[k] = 0;
          end
        end
      end
    end
  end

  task automatic get_obs(input int k, output logic v, output logic [7:0] oh, output int idx);
    case (k)
      0:       begin v = f8.grant_valid; oh = f8.grant_onehot;     idx = int'(f8.grant_idx); end
      1:       begin v = r8.grant_valid; oh = r8.grant_onehot;     idx = int'(r8.grant_idx); end
      default: begin v = r6.grant_valid; oh = 8'(r6.grant_onehot); idx = int'(r6.grant_idx); end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    f8.enable = 1'b0; f8.req = '0; f8.grant_ready = 1'b0;
    r8.enable = 1'b0; r8.req = '0; r8.grant_ready = 1'b0;
    r6.enable = 1'b0; r6.req = '0; r6.grant_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic v; logic [7:0] oh; int idx;
    idle_all();
    rst_n = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      get_obs(k, v, oh, idx);
      n_checks++;
      if (v !== 1'b0 || oh !== 8'h00 || idx != 0)
        $display("FAIL reset_state inst %0d got v=%b oh=%h idx=%0d want 0/00/0", k, v, oh, idx);
      else n_pass++;
    end
    rst_n = 1'b1;
    r8.enable = 1'b1; r8.req = 8'h10;
    tick();
    n_checks++;
    if (r8.grant_valid !== 1'b1 || r8.grant_idx !== 3'd4)
      $display("FAIL pre_reset_grant got v=%b idx=%0d want 1/4", r8.grant_valid, r8.grant_idx);
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (r8.grant_valid !== 1'b0 || r8.grant_onehot !== 8'h00 || r8.grant_idx !== 3'd0)
      $display("FAIL async_reset got v=%b oh=%h idx=%0d want 0/00/0",
               r8.grant_valid, r8.grant_onehot, r8.grant_idx);
    else n_pass++;
    tick();
    idle_all();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      n_checks++;
      if (r8.grant_valid !== 1'b0 || r8.grant_onehot !== 8'h00 || r8.grant_idx !== 3'd0)
        $display("FAIL post_reset_idle got v=%b oh=%h idx=%0d want 0/00/0",
                 r8.grant_valid, r8.grant_onehot, r8.grant_idx);
      else n_pass++;
    end
  endtask

  task automatic test_fixed_priority();
    f8.enable = 1'b1; f8.req = 8'b1010_0110; f8.grant_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (f8.grant_valid !== 1'b1 || f8.grant_idx !== 3'd7 || f8.grant_onehot !== 8'h80)
        $display("FAIL fixed_hold cyc %0d got v=%b idx=%0d oh=%h want 1/7/80",
                 c, f8.grant_valid, f8.grant_idx, f8.grant_onehot);
      else n_pass++;
    end
    f8.grant_ready = 1'b1;
    tick();
    n_checks++;
    if (f8.grant_valid !== 1'b1 || f8.grant_idx !== 3'd7)
      $display("FAIL fixed_regrant got v=%b idx=%0d want 1/7", f8.grant_valid, f8.grant_idx);
    else n_pass++;
    f8.enable = 1'b0; f8.req = '0;
    tick();
    f8.grant_ready = 1'b0;
  endtask

  task automatic test_rr_sweep();
    int exp_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    do_reset();
    r8.enable = 1'b1; r8.req = 8'hFF; r8.grant_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      n_checks++;
      if (r8.grant_valid !== 1'b1 || int'(r8.grant_idx) != exp_seq[c] ||
          r8.grant_onehot !== (8'h01 << exp_seq[c]))
        $display("FAIL rr_sweep step %0d got v=%b idx=%0d oh=%h want idx %0d",
                 c, r8.grant_valid, r8.grant_idx, r8.grant_onehot, exp_seq[c]);
      else n_pass++;
    end
    idle_all();
    tick();
  endtask

  task automatic test_rr_wrap();
    int exp8[4] = '{7, 0, 7, 0};
    int exp6[7] = '{5, 4, 3, 2, 1, 0, 5};
    do_reset();
    r8.enable = 1'b1; r8.req = 8'h81;  r8.grant_ready = 1'b1;
    r6.enable = 1'b1; r6.req = 6'h3F;  r6.grant_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c < 4) begin
        n_checks++;
        if (r8.grant_valid !== 1'b1 || int'(r8.grant_idx) != exp8[c])
          $display("FAIL rr_alt step %0d got v=%b idx=%0d want %0d",
                   c, r8.grant_valid, r8.grant_idx, exp8[c]);
        else n_pass++;
      end
      n_checks++;
      if (r6.grant_valid !== 1'b1 || int'(r6.grant_idx) != exp6[c] || r6.grant_idx >= 3'd6 ||
          r6.grant_onehot !== (6'h01 << exp6[c]))
        $display("FAIL rr_n6 step %0d got v=%b idx=%0d oh=%h want idx %0d",
                 c, r6.grant_valid, r6.grant_idx, r6.grant_onehot, exp6[c]);
      else n_pass++;
    end
    idle_all();
    tick();
  endtask

  task automatic test_hold_enable();
    f8.enable = 1'b1; f8.req = 8'h08; f8.grant_ready = 1'b0;
    tick();
    f8.enable = 1'b0; f8.req = 8'h00;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (f8.grant_valid !== 1'b1 || f8.grant_idx !== 3'd3 || f8.grant_onehot !== 8'h08)
        $display("FAIL hold cyc %0d got v=%b idx=%0d oh=%h want 1/3/08",
                 c, f8.grant_valid, f8.grant_idx, f8.grant_onehot);
      else n_pass++;
      tick();
    end
    f8.grant_ready = 1'b1;
    tick();
    n_checks++;
    if (f8.grant_valid !== 1'b0 || f8.grant_onehot !== 8'h00 || f8.grant_idx !== 3'd0)
      $display("FAIL hold_release got v=%b oh=%h idx=%0d want 0/00/0",
               f8.grant_valid, f8.grant_onehot, f8.grant_idx);
    else n_pass++;
    f8.req = 8'h08;
    tick();
    n_checks++;
    if (f8.grant_valid !== 1'b0)
      $display("FAIL no_grant_disabled got v=%b want 0", f8.grant_valid);
    else n_pass++;
    f8.enable = 1'b1; f8.req = 8'h00;
    tick();
    n_checks++;
    if (f8.grant_valid !== 1'b0)
      $display("FAIL no_grant_noreq got v=%b want 0", f8.grant_valid);
    else n_pass++;
    f8.req = 8'h08; f8.grant_ready = 1'b0;
    tick();
    n_checks++;
    if (f8.grant_valid !== 1'b1 || f8.grant_idx !== 3'd3)
      $display("FAIL regrant got v=%b idx=%0d want 1/3", f8.grant_valid, f8.grant_idx);
    else n_pass++;
    f8.enable = 1'b0; f8.req = 8'h00; f8.grant_ready = 1'b1;
    tick();
    f8.grant_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    f8.enable = 1'b1; f8.req = 8'h80; f8.grant_ready = 1'b0;
    tick();
    n_checks++;
    if (f8.grant_valid !== 1'b1 || f8.grant_idx !== 3'd7)
      $display("FAIL b2b_first got v=%b idx=%0d want 1/7", f8.grant_valid, f8.grant_idx);
    else n_pass++;
    f8.grant_ready = 1'b1; f8.req = 8'h20;
    tick();
    n_checks++;
    if (f8.grant_valid !== 1'b1 || f8.grant_idx !== 3'd5 || f8.grant_onehot !== 8'h20)
      $display("FAIL b2b_switch got v=%b idx=%0d oh=%h want 1/5/20",
               f8.grant_valid, f8.grant_idx, f8.grant_onehot);
    else n_pass++;
    f8.enable = 1'b0; f8.req = 8'h00;
    tick();
    f8.grant_ready = 1'b0;
  endtask

  task automatic test_random();
    logic v; logic [7:0] oh; int idx;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      f8.enable = ($urandom_range(0, 3) != 0);
      r8.enable = ($urandom_range(0, 3) != 0);
      r6.enable = ($urandom_range(0, 3) != 0);
      f8.req = 8'($urandom & $urandom);
      r8.req = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      r6.req = 6'($urandom & $urandom);
      f8.grant_ready = ($urandom_range(0, 2) != 0);
      r8.grant_ready = ($urandom_range(0, 2) != 0);
      r6.grant_ready = ($urandom_range(0, 2) != 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        logic [7:0] exp_oh;
        get_obs(k, v, oh, idx);
        exp_oh = (m_v[k] != 0) ? (8'h01 << m_i[k]) : 8'h00;
        n_checks++;
        if (v !== (m_v[k] != 0) || idx != m_i[k] || oh !== exp_oh)
          $display("FAIL random inst %0d cyc %0d got v=%b idx=%0d oh=%h want v=%0d idx=%0d oh=%h",
                   k, c, v, idx, oh, m_v[k], m_i[k], exp_oh);
        else n_pass++;
      end
    end
    idle_all();
    tick();
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_rr_sweep();
    test_rr_wrap();
    test_hold_enable();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
